// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared state encodings and helpers for the memory arbiter
package mem_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE   = 2'd0;
  localparam arb_state_t ARB_ACCESS = 2'd1;
  localparam arb_state_t ARB_WAIT   = 2'd2;
  localparam arb_state_t ARB_DONE   = 2'd3;

  // Pointer width that stays legal (>=1 bit) when only one core is present
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin winner selection
module mem_arbiter_rr_picker #(
  parameter int NCORES = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NCORES-1:0] i_req,
  input  logic [NCORES-1:0] i_excl,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NCORES-1:0] o_grant,
  output logic              o_valid
);

  logic [NCORES-1:0] w_masked;

  assign w_masked = i_req & ~i_excl;

  // Walk the cores starting at the pointer, wrapping, and grant the first one pending
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NCORES; k++) begin
      for (int j = 0; j < NCORES; j++) begin
        if (!o_valid && w_masked[j] && (j == ((int'(i_ptr) + k) % NCORES))) begin
          o_grant[j] = 1'b1;
          o_valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data memory port among cores
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES  = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic                       Clk,
  input  logic                       Rstn,
  input  logic [NCORES-1:0]          reqRead,
  input  logic [NCORES-1:0]          reqWrite,
  input  logic [NCORES*ADDR_W-1:0]   reqAddr,
  input  logic [NCORES*DATA_W-1:0]   reqWData,
  output logic [NCORES-1:0]          done,
  output logic [NCORES-1:0]          stall,
  output logic [DATA_W-1:0]          rData,
  output logic                       memREAD,
  output logic                       memWRITE,
  output logic [ADDR_W-1:0]          memAddr,
  output logic [DATA_W-1:0]          memWData,
  input  logic [DATA_W-1:0]          memRData,
  output logic                       busy
);

  localparam int PTR_W = ptr_width(NCORES);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t        r_state;
  logic [NCORES-1:0] r_win;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [NCORES-1:0] w_req;
  logic [NCORES-1:0] w_excl;
  logic [NCORES-1:0] w_grant;
  logic              w_valid;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_is_write;

  assign w_req = reqRead | reqWrite;

  // The core just served is kept out of the DONE-cycle arbitration so others go first
  assign w_excl = (r_state == ARB_DONE) ? r_win : '0;

  mem_arbiter_rr_picker #(
    .NCORES (NCORES),
    .PTR_W  (PTR_W)
  ) u_picker (
    .i_req   (w_req),
    .i_excl  (w_excl),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_valid (w_valid)
  );

  // Route the winner's address/data and compute the pointer that follows it
  always_comb begin
    w_addr     = '0;
    w_wdata    = '0;
    w_ptr_next = r_ptr;
    for (int j = 0; j < NCORES; j++) begin
      if (w_grant[j]) begin
        w_addr     = reqAddr[j*ADDR_W +: ADDR_W];
        w_wdata    = reqWData[j*DATA_W +: DATA_W];
        w_ptr_next = PTR_W'((j + 1) % NCORES);
      end
    end
  end

  // A write request wins over a simultaneous read from the same core
  assign w_is_write = |(w_grant & reqWrite);

  // Arbitration FSM: grant and latch in IDLE/DONE, strobe in ACCESS, count latency in WAIT
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      r_state    <= ARB_IDLE;
      r_win      <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ARB_IDLE, ARB_DONE: begin
          if (w_valid) begin
            r_win      <= w_grant;
            r_ptr      <= w_ptr_next;
            r_is_write <= w_is_write;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_state    <= ARB_ACCESS;
          end else begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_ACCESS: begin
          if (MEM_LAT == 1) begin
            r_state <= ARB_DONE;
            if (!r_is_write) r_rdata <= memRData;
          end else begin
            r_state <= ARB_WAIT;
            r_cnt   <= CNT_W'(1);
          end
        end
        ARB_WAIT: begin
          if (r_cnt == CNT_W'(MEM_LAT - 1)) begin
            r_state <= ARB_DONE;
            if (!r_is_write) r_rdata <= memRData;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign done     = (r_state == ARB_DONE) ? r_win : '0;
  assign stall    = w_req & ~done;
  assign rData    = r_rdata;
  assign memREAD  = (r_state == ARB_ACCESS) && !r_is_write;
  assign memWRITE = (r_state == ARB_ACCESS) && r_is_write;
  assign memAddr  = r_addr;
  assign memWData = r_wdata;
  assign busy     = (r_state != ARB_IDLE);

endmodule
